// File: rtl/tmds_pkg.sv
// ----------------------------------------------------------------------------
// tmds_pkg
//   Shared constants and helpers for the RGB888 -> TMDS encoder.
//   - Four DVI control tokens, selected by {C1,C0} during blanking
//   - Reset symbol (control token C=00)
//   - Colour-bar RGB table (white, yellow, cyan, green, magenta, red, blue, black)
//   - popcount8: number of ones in a byte
// ----------------------------------------------------------------------------
package tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;
    localparam logic [9:0] TMDS_RST_SYM = TMDS_CTRL_00;

    // Control token for a blanking cycle
    function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
        logic [9:0] tok;
        case ({c1, c0})
            2'b00:   tok = TMDS_CTRL_00;
            2'b01:   tok = TMDS_CTRL_01;
            2'b10:   tok = TMDS_CTRL_10;
            default: tok = TMDS_CTRL_11;
        endcase
        return tok;
    endfunction

    // Colour-bar colour as {R,G,B}, bar 0 at the left edge of the line
    function automatic logic [23:0] colorbar_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = 24'hFF_FF_FF;   // white
            3'd1:    rgb = 24'hFF_FF_00;   // yellow
            3'd2:    rgb = 24'h00_FF_FF;   // cyan
            3'd3:    rgb = 24'h00_FF_00;   // green
            3'd4:    rgb = 24'hFF_00_FF;   // magenta
            3'd5:    rgb = 24'hFF_00_00;   // red
            3'd6:    rgb = 24'h00_00_FF;   // blue
            default: rgb = 24'h00_00_00;   // black
        endcase
        return rgb;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rgb2tmds_enc_if.sv
// ----------------------------------------------------------------------------
// rgb2tmds_enc_if
//   Video stream into the TMDS encoder and the three encoded symbols out.
//   i_vga_vsync/hsync/de : sync and active-video enable
//   i_vga_r/g/b          : pixel colour, valid when i_vga_de=1
//   test_en              : colour-bar select (only honoured with TMDS_COLORBAR_EN)
//   o_tmds_ch0/1/2       : blue / green / red 10-bit symbols, bit0 sent first
//   master : the video source (drives the stream, observes symbols)
//   slave  : the encoder
// ----------------------------------------------------------------------------
interface rgb2tmds_enc_if;
    logic       i_vga_vsync;
    logic       i_vga_hsync;
    logic       i_vga_de;
    logic [7:0] i_vga_r;
    logic [7:0] i_vga_g;
    logic [7:0] i_vga_b;
    logic       test_en;
    logic [9:0] o_tmds_ch0;
    logic [9:0] o_tmds_ch1;
    logic [9:0] o_tmds_ch2;

    modport master (
        output i_vga_vsync, i_vga_hsync, i_vga_de, i_vga_r, i_vga_g, i_vga_b, test_en,
        input  o_tmds_ch0, o_tmds_ch1, o_tmds_ch2
    );

    modport slave (
        input  i_vga_vsync, i_vga_hsync, i_vga_de, i_vga_r, i_vga_g, i_vga_b, test_en,
        output o_tmds_ch0, o_tmds_ch1, o_tmds_ch2
    );
endinterface

// File: rtl/tmds_chan_enc.sv
// ----------------------------------------------------------------------------
// tmds_chan_enc
//   One TMDS channel: DVI 8b/10b transition-minimised, DC-balanced encoder.
//   Two registered stages, owns its running-disparity counter.
//   sclk, s_rst_n : pixel clock, asynchronous active-low reset
//   d[7:0]        : data byte (stage-1 input)
//   de, c1, c0    : active-video enable and control bits, already delayed by
//                   one cycle so they line up with the stage-1 result
//   q[9:0]        : registered symbol, bit0 sent first
// ----------------------------------------------------------------------------
module tmds_chan_enc
    import tmds_pkg::*;
(
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic [7:0] d,
    input  logic       de,
    input  logic       c1,
    input  logic       c0,
    output logic [9:0] q
);

    // ---------------- stage 1: transition minimisation ----------------
    logic [3:0] n1_d;
    logic       use_xnor;
    logic [8:0] qm_next;
    logic [3:0] n1_qm_next;
    logic [8:0] qm_reg;
    logic [3:0] n1q_reg;
    logic [3:0] n0q_reg;

    always_comb begin
        n1_d     = popcount8(d);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
        qm_next  = '0;
        qm_next[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ d[i]) : (qm_next[i-1] ^ d[i]);
        end
        qm_next[8] = ~use_xnor;
        n1_qm_next = popcount8(qm_next[7:0]);
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            qm_reg  <= '0;
            n1q_reg <= '0;
            n0q_reg <= '0;
        end else begin
            qm_reg  <= qm_next;
            n1q_reg <= n1_qm_next;
            n0q_reg <= 4'd8 - n1_qm_next;
        end
    end

    // ---------------- stage 2: DC balancing ----------------
    logic signed [4:0] cnt_reg;
    logic signed [4:0] cnt_next;
    logic signed [4:0] bal;       // N1q - N0q of the stage-1 word
    logic [9:0]        q_reg;
    logic [9:0]        q_next;

    assign bal = $signed({1'b0, n1q_reg}) - $signed({1'b0, n0q_reg});

    always_comb begin
        q_next   = TMDS_RST_SYM;
        cnt_next = '0;
        if (!de) begin
            // Blanking: disparity restarts at zero so the next active pixel
            // always begins from a balanced line.
            q_next   = ctrl_token(c1, c0);
            cnt_next = '0;
        end else if ((cnt_reg == 5'sd0) || (n1q_reg == n0q_reg)) begin
            q_next   = {~qm_reg[8], qm_reg[8], qm_reg[8] ? qm_reg[7:0] : ~qm_reg[7:0]};
            cnt_next = qm_reg[8] ? (cnt_reg + bal) : (cnt_reg - bal);
        end else if (((cnt_reg > 5'sd0) && (n1q_reg > n0q_reg)) ||
                     ((cnt_reg < 5'sd0) && (n0q_reg > n1q_reg))) begin
            q_next   = {1'b1, qm_reg[8], ~qm_reg[7:0]};
            cnt_next = cnt_reg + (qm_reg[8] ? 5'sd2 : 5'sd0) - bal;
        end else begin
            q_next   = {1'b0, qm_reg[8], qm_reg[7:0]};
            cnt_next = cnt_reg - (qm_reg[8] ? 5'sd0 : 5'sd2) + bal;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            q_reg   <= TMDS_RST_SYM;
            cnt_reg <= '0;
        end else begin
            q_reg   <= q_next;
            cnt_reg <= cnt_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/rgb2tmds_enc.sv
// ----------------------------------------------------------------------------
// rgb2tmds_enc
//   RGB888 + VGA sync/de -> three DVI TMDS symbols per pixel clock.
//   Fixed latency of 2 sclk for data, de, hsync and vsync. No back-pressure.
//   Parameters : H_ACTIVE - active pixels per line (sets colour-bar width)
//   Ports      : sclk     - pixel clock
//                s_rst_n  - asynchronous active-low reset
//                vga      - rgb2tmds_enc_if.slave (video in, symbols out)
//   Build option: define TMDS_COLORBAR_EN to add the 8-bar test pattern
//                selected by vga.test_en; otherwise test_en is ignored.
// ----------------------------------------------------------------------------
module rgb2tmds_enc
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE = 1280
) (
    input  logic            sclk,
    input  logic            s_rst_n,
    rgb2tmds_enc_if.slave   vga
);

    logic [23:0] pix_rgb;   // {R,G,B} entering stage 1

`ifdef TMDS_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [15:0] col_reg;
    logic [15:0] col_next;
    logic [2:0]  bar_idx;

    // col_reg holds the index of the pixel currently on the input
    assign col_next = vga.i_vga_de ? (col_reg + 16'd1) : 16'd0;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            col_reg <= '0;
        end else begin
            col_reg <= col_next;
        end
    end

    // Threshold compare instead of a divider; saturates at bar 7
    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            if (col_reg >= 16'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    assign pix_rgb = vga.test_en ? colorbar_rgb(bar_idx)
                                 : {vga.i_vga_r, vga.i_vga_g, vga.i_vga_b};
`else
    logic unused_test_en;
    assign unused_test_en = vga.test_en;
    assign pix_rgb = {vga.i_vga_r, vga.i_vga_g, vga.i_vga_b};
`endif

    // Sync/de ride one register alongside stage 1 so the channel's stage 2
    // sees them in step with the encoded word.
    logic de_d1_reg;
    logic hs_d1_reg;
    logic vs_d1_reg;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            de_d1_reg <= 1'b0;
            hs_d1_reg <= 1'b0;
            vs_d1_reg <= 1'b0;
        end else begin
            de_d1_reg <= vga.i_vga_de;
            hs_d1_reg <= vga.i_vga_hsync;
            vs_d1_reg <= vga.i_vga_vsync;
        end
    end

    logic [9:0] chan_sym [3];

    // ch0 = blue with {C1,C0}={vsync,hsync}; ch1 = green, ch2 = red with C=00
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [1:0] ctl;
            assign ctl = (gi == 0) ? {vs_d1_reg, hs_d1_reg} : 2'b00;

            tmds_chan_enc u_enc (
                .sclk    (sclk),
                .s_rst_n (s_rst_n),
                .d       (pix_rgb[gi*8 +: 8]),
                .de      (de_d1_reg),
                .c1      (ctl[1]),
                .c0      (ctl[0]),
                .q       (chan_sym[gi])
            );
        end
    endgenerate

    assign vga.o_tmds_ch0 = chan_sym[0];
    assign vga.o_tmds_ch1 = chan_sym[1];
    assign vga.o_tmds_ch2 = chan_sym[2];

endmodule
